// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU operand sequencer.
// Holds function codes, the sequencer state enum and the default width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] FUNC_ADD  = 4'b0000;
  localparam logic [3:0] FUNC_SUB  = 4'b1000;
  localparam logic [3:0] FUNC_XOR  = 4'b0100;
  localparam logic [3:0] FUNC_OR   = 4'b0110;
  localparam logic [3:0] FUNC_AND  = 4'b0111;
  localparam logic [3:0] FUNC_SLT  = 4'b1010;
  localparam logic [3:0] FUNC_SLTU = 4'b1011;
  localparam logic [3:0] FUNC_IDLE = 4'b0100;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH,
    DONE
  } state_t;

  // Codes that need the ALU carry/inversion seed on bit 0.
  function automatic logic has_seed(input logic [3:0] f);
    return f[3] | (f[2:0] == 3'b110);
  endfunction

  // Compare codes return only the final flag.
  function automatic logic is_cmp(input logic [3:0] f);
    return f[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Load/shift register: parallel load, right shift with MSB-in, LSB-out.
// Ports: clk, rst, load, shift, load_data, msb_in -> lsb_out, data.
module serial_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_in,
  output logic             lsb_out,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {msb_in, data[WIDTH-1:1]};
    end
  end

  assign lsb_out = data[0];

endmodule

// File: rtl/alu_serdes.sv
// Bit-serial operand sequencer: parallel op in, LSB-first bits to ALU,
// serial result (or slt flag) collected into a word on a valid/ready port.
// Ports: clk, rst; in_valid/in_ready/in_func/in_opA/in_opB;
//   bitPos/func/opA/opB/carry_in to ALU; result/slt from ALU;
//   out_valid/out_ready/out_data.
// Option: define ALU_SERDES_OUTBUF_EN for a decoupled output buffer.
module alu_serdes
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_func,
  input  logic [WIDTH-1:0] in_opA,
  input  logic [WIDTH-1:0] in_opB,
  output logic [5:0]       bitPos,
  output logic [3:0]       func,
  output logic             opA,
  output logic             opB,
  output logic             carry_in,
  input  logic             result,
  input  logic             slt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  state_t           state;
  state_t           state_nx;
  logic [5:0]       cnt;
  logic [3:0]       func_q;
  logic             accept;
  logic             shifting;
  logic             finishing;
  logic             fin_go;
  logic             a_bit;
  logic             b_bit;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] fin_word;
  logic [WIDTH-1:0] unused_a;
  logic [WIDTH-1:0] unused_b;
  logic             unused_r;

  assign in_ready  = (state == IDLE) & ~rst;
  assign accept    = in_valid & in_ready;
  assign shifting  = (state == SHIFT);
  assign finishing = (state == FINISH);
  assign fin_word  = is_cmp(func_q) ? {{(WIDTH-1){1'b0}}, slt} : r_word;

`ifdef ALU_SERDES_OUTBUF_EN
  logic             buf_valid;
  logic [WIDTH-1:0] buf_data;

  // A buffer drained this cycle can take the new word.
  assign fin_go = finishing & ~(buf_valid & ~out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (fin_go) begin
      buf_valid <= 1'b1;
      buf_data  <= fin_word;
    end else if (out_ready) begin
      buf_valid <= 1'b0;
    end
  end

  assign out_valid = buf_valid;
  assign out_data  = buf_data;
`else
  assign fin_go    = finishing;
  assign out_valid = (state == DONE);
  assign out_data  = r_word;
`endif

  serial_shift_reg #(.WIDTH(WIDTH)) u_a (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (shifting),
    .load_data(in_opA),
    .msb_in   (1'b0),
    .lsb_out  (a_bit),
    .data     (unused_a)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_b (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (shifting),
    .load_data(in_opB),
    .msb_in   (1'b0),
    .lsb_out  (b_bit),
    .data     (unused_b)
  );

  // FINISH reloads the word: the slt flag for compares, itself otherwise.
  serial_shift_reg #(.WIDTH(WIDTH)) u_r (
    .clk      (clk),
    .rst      (rst),
    .load     (finishing),
    .shift    (shifting),
    .load_data(fin_word),
    .msb_in   (result),
    .lsb_out  (unused_r),
    .data     (r_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      func_q <= FUNC_IDLE;
    end else if (accept) begin
      cnt    <= '0;
      func_q <= in_func;
    end else if (shifting) begin
      cnt    <= cnt + 6'd1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (cnt == 6'(WIDTH-1)) state_nx = FINISH;
`ifdef ALU_SERDES_OUTBUF_EN
      FINISH:  if (fin_go) state_nx = IDLE;
`else
      FINISH:  state_nx = DONE;
`endif
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outside SHIFT/FINISH func is XOR so the ALU carry clears.
  always_comb begin
    bitPos   = '0;
    func     = FUNC_IDLE;
    opA      = 1'b0;
    opB      = 1'b0;
    carry_in = 1'b0;
    unique case (state)
      SHIFT: begin
        bitPos   = cnt;
        func     = func_q;
        opA      = a_bit;
        opB      = b_bit;
        carry_in = (cnt == 6'd0) & has_seed(func_q);
      end
      FINISH: begin
        bitPos = 6'(WIDTH);
        func   = func_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_serdes.sv
// Self-checking bench for alu_serdes with a behavioural serial ALU stub,
// a timeline model of the sequencer and a word-level result scoreboard.
`timescale 1ns/1ps
module tb_alu_serdes;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_func = 4'b0;
  logic [W-1:0] in_opA = '0;
  logic [W-1:0] in_opB = '0;
  logic [5:0]   bitPos;
  logic [3:0]   func;
  logic         opA;
  logic         opB;
  logic         carry_in;
  logic         result;
  logic         slt;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;

  alu_serdes #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_func  (in_func),
    .in_opA   (in_opA),
    .in_opB   (in_opB),
    .bitPos   (bitPos),
    .func     (func),
    .opA      (opA),
    .opB      (opB),
    .carry_in (carry_in),
    .result   (result),
    .slt      (slt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask

  task automatic fail_to(input string n);
    ntot++;
    $display("FAIL %s: got timeout want event", n);
  endtask

  // Word-level reference: what the ALU op means arithmetically.
  function automatic logic [31:0] model(input logic [3:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (f)
      4'b1000: return a - b;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1010: return {31'b0, $signed(a) < $signed(b)};
      4'b1011: return {31'b0, a < b};
      default: return a + b;
    endcase
  endfunction

  // Serial ALU stub fed only by the DUT's serial outputs.
  logic         cr;
  logic         bb;
  logic         cin;
  logic         sum;
  logic [W-1:0] sa;
  logic [W-1:0] sb;

  always_comb begin
    bb  = opB ^ func[3];
    cin = (bitPos == 6'd0) ? carry_in : cr;
    sum = opA ^ bb ^ cin;
    case (func)
      4'b0100: result = opA ^ opB;
      4'b0110: result = opA | opB;
      4'b0111: result = opA & opB;
      default: result = sum;
    endcase
    slt = func[0] ? (sa < sb) : ($signed(sa) < $signed(sb));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cr <= 1'b0;
    else cr <= (opA & bb) | (cin & (opA ^ bb));
  end

  always @(posedge clk) begin
    if (bitPos < 6'd32) begin
      sa[bitPos[4:0]] <= opA;
      sb[bitPos[4:0]] <= opB;
    end
  end

  // Timeline model: ph=-1 idle, 1..32 bit k=ph-1, 33 finish, 34 done.
  int           ph = -1;
  logic [31:0]  ca;
  logic [31:0]  cb;
  logic [3:0]   cf;
  logic [31:0]  q[$];
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [31:0]  pd = '0;
  logic [31:0]  last_out = '0;
  int           ndeliv = 0;

  always @(negedge clk) begin
    logic full;
    int   k;
    if (rst) begin
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_func", 32'(func), 32'h4);
      chk("rst_pins", {bitPos, opA, opB, carry_in}, 0);
      ph = -1;
      q.delete();
      pv = 1'b0;
    end else begin
      full = (q.size() != 0);
      chk("out_valid", 32'(out_valid), 32'(full));
      if (pv && !pr && out_valid) chk("hold_data", out_data, pd);
      if (out_valid && out_ready && full) begin
        chk("out_data", out_data, q[0]);
        last_out = out_data;
        ndeliv++;
        void'(q.pop_front());
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      if (ph < 0) begin
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_func", 32'(func), 32'h4);
        chk("idle_pins", {bitPos, opA, opB, carry_in}, 0);
        if (in_valid) begin
          ca = in_opA;
          cb = in_opB;
          cf = in_func;
          ph = 1;
        end
      end else if (ph <= 32) begin
        k = ph - 1;
        chk("shift_in_ready", 32'(in_ready), 0);
        chk("shift_bitpos", 32'(bitPos), 32'(k));
        chk("shift_func", 32'(func), 32'(cf));
        chk("shift_opA", 32'(opA), 32'(ca[k]));
        chk("shift_opB", 32'(opB), 32'(cb[k]));
        chk("shift_carry", 32'(carry_in),
            32'(k == 0 && (cf[3] || cf[2:0] == 3'b110)));
        ph++;
      end else if (ph == 33) begin
        chk("fin_in_ready", 32'(in_ready), 0);
        chk("fin_bitpos", 32'(bitPos), 32);
        chk("fin_func", 32'(func), 32'(cf));
        chk("fin_pins", {opA, opB, carry_in}, 0);
`ifdef ALU_SERDES_OUTBUF_EN
        if (!(full && !out_ready)) begin
          q.push_back(model(cf, ca, cb));
          ph = -1;
        end
`else
        q.push_back(model(cf, ca, cb));
        ph = 34;
`endif
      end else begin
        chk("done_in_ready", 32'(in_ready), 0);
        chk("done_func", 32'(func), 32'h4);
        if (out_ready) ph = -1;
      end
    end
  end

  logic rnd = 1'b0;

  task automatic jiggle();
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    int  n = 0;
    logic ok = 1'b0;
    in_func  = f;
    in_opA   = a;
    in_opB   = b;
    in_valid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      if (in_ready && !rst) ok = 1'b1;
      else if (++n > 300) begin
        fail_to("accept");
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
        jiggle();
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_func  = 4'($urandom);
    in_opA   = $urandom;
    in_opB   = $urandom;
    jiggle();
  endtask

  task automatic drain();
    int n = 0;
    while ((ph >= 0 || q.size() != 0) && n < 600) begin
      @(posedge clk); #1;
      jiggle();
      n++;
    end
    if (n >= 600) fail_to("drain");
  endtask

  task automatic run(input string nm, input logic [3:0] f,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit);
    issue(f, a, b);
    drain();
    chk(nm, last_out, lit);
  endtask

`ifdef ALU_SERDES_OUTBUF_EN
  localparam logic BP_RDY = 1'b1;
`else
  localparam logic BP_RDY = 1'b0;
`endif

  logic [3:0]  fl[9] = '{4'b0000, 4'b1000, 4'b0100, 4'b0110, 4'b0111,
                         4'b1010, 4'b1011, 4'b0001, 4'b0101};
  logic [31:0] sp[4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000,
                         32'h7FFF_FFFF};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    int n;
    int d0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // ADD with latency: out_valid after the 34th edge, accept edge = 1st.
    issue(4'b0000, 32'h5, 32'h3);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency_edges", 32'(n + 1), 34);
    drain();
    chk("lit_add", last_out, 32'h8);

    run("lit_sub", 4'b1000, 32'h0, 32'h1, 32'hFFFF_FFFF);
    run("lit_or", 4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    run("lit_and", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    run("lit_xor", 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    run("lit_slt", 4'b1010, 32'hFFFF_FFFF, 32'h1, 32'h1);
    run("lit_sltu", 4'b1011, 32'hFFFF_FFFF, 32'h1, 32'h0);
    run("lit_unknown", 4'b0101, 32'h7, 32'h9, 32'h10);

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    issue(4'b0000, 32'h1234_5678, 32'h1111_1111);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_to("bp_valid");
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'(BP_RDY));
      chk("bp_data", out_data, 32'h2345_6789);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a shift.
    issue(4'b1000, 32'hDEAD_BEEF, 32'h1234_5678);
    n = 0;
    while (bitPos != 6'd14 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_to("rst_bitpos");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_bitpos", 32'(bitPos), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    run("lit_after_rst", 4'b0000, 32'h1, 32'h1, 32'h2);

`ifdef ALU_SERDES_OUTBUF_EN
    // Two ops with the consumer stalled: the second waits in FINISH.
    out_ready = 1'b0;
    d0 = ndeliv;
    issue(4'b0000, 32'h1, 32'h2);
    issue(4'b0000, 32'h3, 32'h4);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("stall_bitpos", 32'(bitPos), 32);
    chk("stall_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    chk("stall_count", 32'(ndeliv - d0), 2);
    chk("stall_last", last_out, 32'h7);
`endif

    // Randomized traffic with random consumer stalls.
    rnd = 1'b1;
    repeat (40) issue(fl[$urandom_range(0, 8)], pick(), pick());
    rnd = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
